fft_twiddle_stage: RTL and testbench
====================================

# fft_twiddle_stage

Inter-stage twiddle multiplier for the 16-point radix-4 DIF FFT. It sits between the first-stage bank of four radix-4 butterflies and the second stage. On a start pulse it captures the 16 complex first-stage outputs. It then multiplies each one by its W16 twiddle factor through a single shared, 2-stage pipelined complex multiplier, at one point per cycle. It holds the 16 results in a register bank that feeds the second-stage butterflies.

## Interface
- No parameters. Fixed at 16 points, 16-bit two's-complement data, Q1.14 twiddles.
- mclk  in  1  system clock; all state updates on rising edge
- puc_rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request; accepted only when busy=0
- din_re  in  256  real parts; point p occupies [16*p +: 16], p = 4*b + k (b = butterfly 0..3, k = output A..D = 0..3)
- din_im  in  256  imaginary parts, same packing
- dout_re  out  256  twiddled real parts, same packing
- dout_im  out  256  twiddled imaginary parts, same packing
- busy  out  1  high while a 16-point pass is in progress
- done  out  1  one-cycle pulse; the pass is complete and dout is valid
- ovf  out  1  sticky saturation flag for the current pass

## Operation
- Twiddle exponent e = b*k. Only e ∈ {0,1,2,3,4,6,9} occurs.
- Twiddle constants (wr, wi) in Q1.14, W = cos(2πe/16) − j·sin(2πe/16):
  - e=0: (16384, 0)
  - e=1: (15137, −6270)
  - e=2: (11585, −11585)
  - e=3: (6270, −15137)
  - e=4: (0, −16384)
  - e=6: (−11585, −11585)
  - e=9: (−15137, 6270)
- Pipeline stage 1 registers four signed 32-bit products: ar·wr, ai·wi, ar·wi, ai·wr.
- Pipeline stage 2 forms two 33-bit sums:
  - re = ar·wr − ai·wi
  - im = ar·wi + ai·wr
- Each sum is then rounded and saturated:
  - add 8192, arithmetic shift right 14 (round half up);
  - saturate to [−32768, 32767];
  - any saturation sets ovf.
- e=0 points bypass the arithmetic. Input is copied to output bit-exactly with identical pipeline timing, and never set ovf.
- FSM states:
  - IDLE: on start, capture din_re/din_im into the input bank, clear ovf, set busy, counter = 0 → RUN.
  - RUN: issue point p = counter each cycle for p = 0..15. After issuing p=15 → DRAIN.
  - DRAIN: 2 cycles for the pipeline to empty. The last writeback asserts done, clears busy → IDLE.
- start while busy=1 is ignored. Input changes during a pass are ignored because the data is captured.
- dout is updated point by point during a pass. It is guaranteed only from the done cycle until the next accepted start.

## Timing
- Reset (puc_rst_n=0 at an edge):
  - busy=0, done=0, ovf=0;
  - dout_re = dout_im = 0;
  - counter = 0, pipeline valids = 0;
  - FSM → IDLE.
- Reset mid-pass aborts the pass with no done pulse.
- Edge E0 with start=1 and busy=0: capture; busy=1 from the cycle after E0.
- Point p enters stage 1 at edge E(p+1) and is written to dout at edge E(p+3).
- Last write occurs at E18. At the same edge done←1 and busy←0; done←0 at E19.
- Latency from start to done: 18 cycles. Throughput: one pass per 19 cycles.
- start sampled in the done cycle (busy=0) is accepted. The next pass begins without gaps, and ovf is cleared at that edge.
- ovf stays valid from done until the next accepted start.

## Test plan
- Reset, then idle 5 cycles:
  - required: dout all 0, busy=0, done=0, ovf=0;
  - start asserted with puc_rst_n=0 is ignored.
- Impulse at p=5 (e=1), din=(16384,0), all other points 0, start at E0:
  - required: done high exactly in the cycle after E18;
  - dout[5] = (15137, −6270), all other points 0, ovf=0.
- Bypass: p=0,4,8,12 and p=1..3 loaded with (−32768, 32767):
  - required: identical outputs, ovf=0.
- Saturation at p=10 (e=4), din=(−32768, 0):
  - required: dout[10] = (0, 32767), ovf=1;
  - a following pass with all-zero input clears ovf at start and ends with ovf=0.
- Rounding at p=5, din=(1,0):
  - required: dout[5] = (1, 0);
  - p=15 (e=9) with din=(0,1) gives (0, −1).
- Handshake:
  - start pulsed at E5 of a pass is ignored, with done still at E18;
  - start in the done cycle launches a new pass, with done 19 cycles later;
  - puc_rst_n=0 at E8 of a pass clears all outputs and produces no done pulse.

Source files
------------

// File: rtl/fft_twiddle_stage.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_stage
// Function : W16 inter-stage twiddle multiply for a 16-point radix-4 DIF FFT,
//            one point per cycle through a shared 2-stage complex multiplier.
// Revision : 1.0  initial release
// ============================================================================
module fft_twiddle_stage (
  input  logic         mclk,
  input  logic         puc_rst_n,
  input  logic         start,
  input  logic [255:0] din_re,
  input  logic [255:0] din_im,
  output logic [255:0] dout_re,
  output logic [255:0] dout_im,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic signed [32:0] c_ROUND = 33'sd8192;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [255:0]        r_in_re;
  logic [255:0]        r_in_im;
  logic [255:0]        r_out_re;
  logic [255:0]        r_out_im;

  logic                r_s1_vld;
  logic                r_s1_byp;
  logic [3:0]          r_s1_idx;
  logic [15:0]         r_s1_are;
  logic [15:0]         r_s1_aim;
  logic signed [31:0]  r_s1_rr;
  logic signed [31:0]  r_s1_ii;
  logic signed [31:0]  r_s1_ri;
  logic signed [31:0]  r_s1_ir;

  logic                r_s2_vld;
  logic                r_s2_byp;
  logic [3:0]          r_s2_idx;
  logic [15:0]         r_s2_are;
  logic [15:0]         r_s2_aim;
  logic signed [32:0]  r_s2_re;
  logic signed [32:0]  r_s2_im;

  logic                w_accept;
  logic                w_issue;
  logic                w_last_drain;
  logic [3:0]          w_e;
  logic                w_byp;
  logic signed [15:0]  w_ar;
  logic signed [15:0]  w_ai;
  logic signed [15:0]  w_wr;
  logic signed [15:0]  w_wi;
  logic [16:0]         w_re_rs;
  logic [16:0]         w_im_rs;
  logic [15:0]         w_wb_re;
  logic [15:0]         w_wb_im;
  logic                w_wb_sat;

  // Returns {saturated, value} after round-half-up and >>14.
  function automatic logic [16:0] rnd_sat(input logic signed [32:0] s);
    logic signed [32:0] sh;
    sh = (s + c_ROUND) >>> 14;
    if (sh > 33'sd32767)
      rnd_sat = {1'b1, 16'h7FFF};
    else if (sh < -33'sd32768)
      rnd_sat = {1'b1, 16'h8000};
    else
      rnd_sat = {1'b0, sh[15:0]};
  endfunction

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_issue      = (r_state == S_RUN);
  assign w_last_drain = (r_state == S_DRAIN) && (r_cnt == 4'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)           w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 4'd15)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == 4'd1)   w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Point p = 4*b + k takes exponent b*k.
  assign w_e   = {2'b00, r_cnt[3:2]} * {2'b00, r_cnt[1:0]};
  assign w_byp = (w_e == 4'd0);
  assign w_ar  = r_in_re[{r_cnt, 4'b0000} +: 16];
  assign w_ai  = r_in_im[{r_cnt, 4'b0000} +: 16];

  always_comb begin
    w_wr = 16'sd16384;
    w_wi = 16'sd0;
    case (w_e)
      4'd1:    begin w_wr =  16'sd15137; w_wi = -16'sd6270;  end
      4'd2:    begin w_wr =  16'sd11585; w_wi = -16'sd11585; end
      4'd3:    begin w_wr =  16'sd6270;  w_wi = -16'sd15137; end
      4'd4:    begin w_wr =  16'sd0;     w_wi = -16'sd16384; end
      4'd6:    begin w_wr = -16'sd11585; w_wi = -16'sd11585; end
      4'd9:    begin w_wr = -16'sd15137; w_wi =  16'sd6270;  end
      default: begin w_wr =  16'sd16384; w_wi =  16'sd0;     end
    endcase
  end

  assign w_re_rs  = rnd_sat(r_s2_re);
  assign w_im_rs  = rnd_sat(r_s2_im);
  assign w_wb_re  = r_s2_byp ? r_s2_are : w_re_rs[15:0];
  assign w_wb_im  = r_s2_byp ? r_s2_aim : w_im_rs[15:0];
  assign w_wb_sat = !r_s2_byp && (w_re_rs[16] || w_im_rs[16]);

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_out_re <= '0;
      r_out_im <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_s1_vld <= w_issue;
      r_s2_vld <= r_s1_vld;
      if (w_accept) begin
        r_cnt  <= 4'd0;
        r_busy <= 1'b1;
        r_ovf  <= 1'b0;
      end else if (w_last_drain) begin
        r_cnt  <= 4'd0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else if (r_state != S_IDLE) begin
        r_cnt  <= r_cnt + 4'd1;
      end
      if (r_s2_vld) begin
        r_out_re[{r_s2_idx, 4'b0000} +: 16] <= w_wb_re;
        r_out_im[{r_s2_idx, 4'b0000} +: 16] <= w_wb_im;
        if (w_wb_sat) r_ovf <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge mclk) begin
    if (w_accept) begin
      r_in_re <= din_re;
      r_in_im <= din_im;
    end
    r_s1_byp <= w_byp;
    r_s1_idx <= r_cnt;
    r_s1_are <= w_ar;
    r_s1_aim <= w_ai;
    r_s1_rr  <= w_ar * w_wr;
    r_s1_ii  <= w_ai * w_wi;
    r_s1_ri  <= w_ar * w_wi;
    r_s1_ir  <= w_ai * w_wr;
    r_s2_byp <= r_s1_byp;
    r_s2_idx <= r_s1_idx;
    r_s2_are <= r_s1_are;
    r_s2_aim <= r_s1_aim;
    r_s2_re  <= {r_s1_rr[31], r_s1_rr} - {r_s1_ii[31], r_s1_ii};
    r_s2_im  <= {r_s1_ri[31], r_s1_ri} + {r_s1_ir[31], r_s1_ir};
  end

  assign dout_re = r_out_re;
  assign dout_im = r_out_im;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_twiddle_stage
// Function : Scoreboard bench for fft_twiddle_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_twiddle_stage;

  logic         mclk = 1'b0;
  logic         puc_rst_n;
  logic         start;
  logic [255:0] din_re;
  logic [255:0] din_im;
  logic [255:0] dout_re;
  logic [255:0] dout_im;
  logic         busy;
  logic         done;
  logic         ovf;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] sb_re_q[$];
  logic [15:0] sb_im_q[$];
  bit          sb_ovf_q[$];

  fft_twiddle_stage dut (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .start     (start),
    .din_re    (din_re),
    .din_im    (din_im),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic void twiddle(input int e, output int wr, output int wi);
    case (e)
      1:       begin wr =  15137; wi =  -6270;  end
      2:       begin wr =  11585; wi = -11585;  end
      3:       begin wr =   6270; wi = -15137;  end
      4:       begin wr =      0; wi = -16384;  end
      6:       begin wr = -11585; wi = -11585;  end
      9:       begin wr = -15137; wi =   6270;  end
      default: begin wr =  16384; wi =      0;  end
    endcase
  endfunction

  function automatic logic [15:0] sat16(input longint v, inout bit ov);
    logic [63:0] u;
    if (v > 32767)  begin ov = 1'b1; return 16'h7FFF; end
    if (v < -32768) begin ov = 1'b1; return 16'h8000; end
    u = v;
    return u[15:0];
  endfunction

  task automatic push_expected(input logic [255:0] re, input logic [255:0] im);
    bit ov = 1'b0;
    for (int p = 0; p < 16; p++) begin
      logic [15:0] xr, xi;
      longint ar, ai, sr, si;
      int wr, wi, e;
      xr = re[16*p +: 16];
      xi = im[16*p +: 16];
      e  = (p / 4) * (p % 4);
      if (e == 0) begin
        sb_re_q.push_back(xr);
        sb_im_q.push_back(xi);
      end else begin
        ar = longint'($signed(xr));
        ai = longint'($signed(xi));
        twiddle(e, wr, wi);
        sr = (ar * wr - ai * wi + 8192) >>> 14;
        si = (ar * wi + ai * wr + 8192) >>> 14;
        sb_re_q.push_back(sat16(sr, ov));
        sb_im_q.push_back(sat16(si, ov));
      end
    end
    sb_ovf_q.push_back(ov);
  endtask

  task automatic rand_din(output logic [255:0] r, output logic [255:0] i);
    for (int p = 0; p < 16; p++) begin
      r[16*p +: 16] = 16'($urandom);
      i[16*p +: 16] = 16'($urandom);
    end
  endtask

  // Drives a one-cycle start; returns just after the accepting edge E0.
  task automatic launch(input logic [255:0] re, input logic [255:0] im, input bit do_push);
    din_re = re;
    din_im = im;
    if (do_push) push_expected(re, im);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Scoreboard consumer: scores the whole bank in the done cycle.
  always @(negedge mclk) begin
    if (puc_rst_n === 1'b1 && done === 1'b1) begin
      if (sb_ovf_q.size() == 0 || sb_re_q.size() < 16) begin
        n_total++;
        $display("FAIL sb_unexpected_done: got done=1 required no pass pending");
      end else begin
        bit eo;
        for (int p = 0; p < 16; p++) begin
          logic [15:0] er, ei;
          er = sb_re_q.pop_front();
          ei = sb_im_q.pop_front();
          n_total++;
          if (dout_re[16*p +: 16] !== er || dout_im[16*p +: 16] !== ei)
            $display("FAIL sb_point p=%0d got (%0d,%0d) required (%0d,%0d)", p,
                     $signed(dout_re[16*p +: 16]), $signed(dout_im[16*p +: 16]),
                     $signed(er), $signed(ei));
          else
            n_pass++;
        end
        eo = sb_ovf_q.pop_front();
        n_total++;
        if (ovf !== eo) $display("FAIL sb_ovf got %b required %b", ovf, eo);
        else            n_pass++;
      end
    end
  end

  task automatic test_reset();
    logic [255:0] r, i;
    rand_din(r, i);
    din_re = r; din_im = i;
    puc_rst_n = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b required 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b required 0", done); else n_pass++;
    n_total++; if (ovf  !== 1'b0) $display("FAIL rst_ovf got %b required 0", ovf);   else n_pass++;
    n_total++; if (dout_re !== '0) $display("FAIL rst_dout_re got %h required 0", dout_re); else n_pass++;
    n_total++; if (dout_im !== '0) $display("FAIL rst_dout_im got %h required 0", dout_im); else n_pass++;
    puc_rst_n = 1'b1;
    start = 1'b0;
    repeat (5) tick();
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b required 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL idle_done got %b required 0", done); else n_pass++;
    n_total++; if (dout_re !== '0 || dout_im !== '0)
      $display("FAIL idle_dout got re=%h im=%h required 0", dout_re, dout_im); else n_pass++;
  endtask

  task automatic test_impulse();
    logic [255:0] r = '0, i = '0;
    int c;
    r[16*5 +: 16] = 16'sd16384;
    launch(r, i, 1'b1);
    n_total++; if (busy !== 1'b1) $display("FAIL imp_busy got %b required 1", busy); else n_pass++;
    wait_done(c);
    n_total++; if (c != 18) $display("FAIL imp_done_cycle got %0d required 18", c); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL imp_done_width got done=%b busy=%b required 0/0", done, busy); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [255:0] r = '0, i = '0;
    int c;
    int pts[7] = '{0, 4, 8, 12, 1, 2, 3};
    foreach (pts[n]) begin
      r[16*pts[n] +: 16] = 16'h8000;
      i[16*pts[n] +: 16] = 16'h7FFF;
    end
    launch(r, i, 1'b1);
    wait_done(c);
    n_total++; if (c != 18) $display("FAIL byp_done_cycle got %0d required 18", c); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL byp_ovf got %b required 0", ovf); else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    logic [255:0] r = '0, i = '0;
    int c;
    r[16*10 +: 16] = 16'h8000;
    launch(r, i, 1'b1);
    wait_done(c);
    n_total++; if (c != 18) $display("FAIL sat_done_cycle got %0d required 18", c); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL sat_ovf got %b required 1", ovf); else n_pass++;
    tick();
    launch('0, '0, 1'b1);
    n_total++; if (ovf !== 1'b0) $display("FAIL sat_ovf_clear got %b required 0", ovf); else n_pass++;
    wait_done(c);
    n_total++; if (ovf !== 1'b0 || c != 18)
      $display("FAIL zero_pass got ovf=%b cycle=%0d required 0/18", ovf, c); else n_pass++;
    tick();
  endtask

  task automatic test_rounding();
    logic [255:0] r = '0, i = '0;
    int c;
    r[16*5 +: 16]  = 16'd1;
    i[16*15 +: 16] = 16'd1;
    launch(r, i, 1'b1);
    wait_done(c);
    n_total++; if (c != 18) $display("FAIL rnd_done_cycle got %0d required 18", c); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [255:0] r, i;
    int c;
    for (int n = 0; n < 3; n++) begin
      rand_din(r, i);
      launch(r, i, 1'b1);
      wait_done(c);
      n_total++; if (c != 18) $display("FAIL rand_done_cycle got %0d required 18", c); else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] r, i, gr, gi;
    int c;
    rand_din(r, i);
    launch(r, i, 1'b1);
    c = 0;
    while (!done && c < 40) begin
      if (c == 4) begin
        rand_din(gr, gi);
        din_re = gr; din_im = gi;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      c++;
    end
    start = 1'b0;
    n_total++; if (c != 18) $display("FAIL b2b_ignored_start got done at %0d required 18", c); else n_pass++;
    rand_din(r, i);
    launch(r, i, 1'b1);
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_restart_busy got %b required 1", busy); else n_pass++;
    wait_done(c);
    n_total++; if (c != 18) $display("FAIL b2b_second_done got %0d required 18", c); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [255:0] r, i;
    bit saw_done = 1'b0;
    rand_din(r, i);
    launch(r, i, 1'b0);
    repeat (7) tick();
    puc_rst_n = 1'b0;
    tick();
    puc_rst_n = 1'b1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0)
      $display("FAIL mid_rst_flags got busy=%b done=%b ovf=%b required 0/0/0", busy, done, ovf); else n_pass++;
    n_total++; if (dout_re !== '0 || dout_im !== '0)
      $display("FAIL mid_rst_dout got re=%h im=%h required 0", dout_re, dout_im); else n_pass++;
    repeat (30) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    n_total++; if (saw_done) $display("FAIL mid_rst_no_done got done=1 required 0"); else n_pass++;
  endtask

  initial begin
    start  = 1'b0;
    din_re = '0;
    din_im = '0;
    puc_rst_n = 1'b0;
    test_reset();
    test_impulse();
    test_bypass();
    test_saturation();
    test_rounding();
    test_random();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    n_total++; if (sb_re_q.size() != 0 || sb_ovf_q.size() != 0)
      $display("FAIL sb_leftover got %0d points required 0", sb_re_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
